// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-index counter width for an n-bit word.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo-MOD bit counter with synchronous clear, enable and terminal-count flag.
module bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned MOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc_c
);

  localparam int unsigned W = cnt_w(MOD);
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt;

  // Clear wins over count so a reload on the terminal edge restarts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tc_c = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: loads a word on ld && ready and shifts it out
// one bit per shift_en tick, with frame_start/done markers.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             ld,
  output logic             ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             tc_c;
  logic             last_c;
  logic             load_c;
  logic             cnt_en_c;

  assign last_c   = (state == ST_SHIFT) && tc_c && shift_en;
  assign ready    = !rst && ((state == ST_IDLE) || last_c);
  assign load_c   = ld && ready;
  assign cnt_en_c = (state == ST_SHIFT) && shift_en;

  bit_counter #(.MOD(WIDTH)) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en_c),
    .clr  (load_c),
    .tc_c (tc_c)
  );

  // Control FSM and shift register; a reload on the last-bit edge chains frames gap-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= last_c;
      if (load_c) begin
        state       <= ST_SHIFT;
        shreg       <= data;
        sout_valid  <= 1'b1;
        frame_start <= 1'b1;
      end else if (last_c) begin
        state       <= ST_IDLE;
        shreg       <= '0;
        sout_valid  <= 1'b0;
        frame_start <= 1'b0;
      end else if (cnt_en_c) begin
        frame_start <= 1'b0;
        if (MSB_FIRST) begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
      end
    end
  end

  assign sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

endmodule
